spell_spi_mem: RTL
==================

SPELL_SPI_MEM -- requirements
Module: spell_spi_mem

Interface
REQ-001 SHALL provide parameter READ_CMD, default 8'h03, SPI read opcode.
REQ-002 SHALL provide parameter WRITE_CMD, default 8'h02, SPI write opcode.
REQ-003 SHALL use clock clk, rising edge; reset rst_n, synchronous, active-low.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port select  input  1  transaction request, held high until data_ready is seen.
REQ-007 SHALL have port write  input  1  1 = write transaction, 0 = read.
REQ-008 SHALL have port memory_type_data  input  1  0 = code space, 1 = data space.
REQ-009 SHALL have port addr  input  8  byte address within the selected space.
REQ-010 SHALL have port data_in  input  8  write data.
REQ-011 SHALL have port data_out  output  8  last read byte.
REQ-012 SHALL have port data_ready  output  1  transaction complete.
REQ-013 SHALL have ports spi_cs (active-low), spi_clk, spi_mosi (outputs, 1 bit each) and spi_miso (input, 1 bit); all outputs registered.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE.
REQ-015 IDLE: spi_cs=1, spi_clk=0, data_ready=0; on an edge with select=1, latch inputs, load a 32-bit frame {cmd, 7'b0, memory_type_data, addr, data_in} (cmd=WRITE_CMD if write else READ_CMD; data_in replaced by 8'h00 for reads), and enter SHIFT.
REQ-016 SHIFT: spi_cs=0; frame sent MSB first, 2 clk cycles per bit (SPI mode 0): phase 0 spi_clk=0 with spi_mosi = current bit; phase 1 spi_clk=1.
REQ-017 spi_mosi SHALL change only at the phase 1->0 transition (or SHIFT entry), never while spi_clk=1.
REQ-018 On the edge entering phase 1 of bits 24..31 of a read, spi_miso SHALL be shifted into a receive register, MSB first; spi_miso ignored otherwise.
REQ-019 A 5-bit bit counter SHALL count 0..31; after phase 1 of bit 31 (64 clk cycles in SHIFT) enter DONE.
REQ-020 DONE: spi_cs=1, spi_clk=0, data_ready=1; on reads data_out SHALL be updated on DONE entry; on writes data_out SHALL be unchanged.
REQ-021 DONE SHALL hold data_ready=1 while select=1; when select=0, next cycle IDLE with data_ready=0; a new transaction requires select sampled low in between.
REQ-022 Input changes during SHIFT/DONE SHALL be ignored (latched values used).
REQ-023 select dropping to 0 during SHIFT SHALL abort: next cycle IDLE, spi_cs=1, spi_clk=0, data_ready=0, data_out unchanged.
REQ-024 data_ready SHALL be 1 only in DONE; it SHALL never be 1 while spi_cs=0.

Reset
REQ-025 rst_n=0 at any edge, including mid-SHIFT, SHALL force IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, data_ready=0, data_out=8'h00, bit counter=0, phase=0.
REQ-026 First transaction after reset release SHALL start only on an edge with rst_n=1 and select=1.

Verification
REQ-027 Read code: select=1, write=0, type=0, addr=8'h5A, SPI model returns 8'hC3 -> MOSI frame 03 00 5A xx, data_out=8'hC3, data_ready high 65 edges after start.
REQ-028 Write data: select=1, write=1, type=1, addr=8'h10, data_in=8'hA5 -> MOSI frame 02 01 10 A5, data_out unchanged, exactly 32 spi_clk rising edges per CS-low window.
REQ-029 Handshake: hold select high 10 cycles after data_ready -> data_ready stays 1, spi_cs stays 1, no second transaction; drop select -> data_ready=0 next cycle.
REQ-030 Abort: drop select after bit 12 -> spi_cs=1 next cycle, data_ready never asserted, data_out unchanged.
REQ-031 Reset mid-SHIFT (bit 20) -> all outputs at reset values next cycle; subsequent read of addr 8'hFF returns model value correctly.
REQ-032 Protocol checker throughout: mosi stable while spi_clk=1, spi_clk=0 whenever spi_cs=1, data_ready implies spi_cs=1.

Source files
------------

// File: rtl/spell_spi_mem.sv
// SPI memory bridge: one 32-bit mode-0 frame per request, {cmd, 7'b0, space, addr, data}.
// Read data is captured from spi_miso during the final byte and presented on data_out.
module spell_spi_mem #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       select,
    input  logic       write,
    input  logic       memory_type_data,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       spi_cs,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      r_state, w_next;
    logic [30:0] r_frame;     // remaining bits after the one currently on spi_mosi
    logic [4:0]  r_bit;
    logic        r_phase;
    logic        r_write;
    logic [7:0]  r_rx;
    logic [31:0] w_frame;
    logic        w_start, w_abort, w_finish;

    assign w_frame = {(write ? WRITE_CMD : READ_CMD), 7'b0, memory_type_data, addr,
                      (write ? data_in : 8'h00)};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_abort  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                if (select) begin
                    w_next  = SHIFT;
                    w_start = 1'b1;
                end
            end
            SHIFT: begin
                if (!select) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_phase && (r_bit == 5'd31)) begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end
            end
            DONE: begin
                if (!select) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spi_cs     <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b0;
            data_ready <= 1'b0;
            data_out   <= '0;
            r_frame    <= '0;
            r_bit      <= '0;
            r_phase    <= 1'b0;
            r_write    <= 1'b0;
            r_rx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    spi_cs     <= 1'b1;
                    spi_clk    <= 1'b0;
                    data_ready <= 1'b0;
                    r_bit      <= '0;
                    r_phase    <= 1'b0;
                    if (w_start) begin
                        r_write  <= write;
                        r_frame  <= w_frame[30:0];
                        spi_mosi <= w_frame[31];
                        spi_cs   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_abort) begin
                        spi_cs  <= 1'b1;
                        spi_clk <= 1'b0;
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                    end else if (!r_phase) begin
                        // Rising spi_clk: sample miso only during the data byte of a read
                        spi_clk <= 1'b1;
                        r_phase <= 1'b1;
                        if (!r_write && (r_bit[4:3] == 2'b11))
                            r_rx <= {r_rx[6:0], spi_miso};
                    end else if (w_finish) begin
                        spi_clk    <= 1'b0;
                        spi_cs     <= 1'b1;
                        data_ready <= 1'b1;
                        r_bit      <= '0;
                        r_phase    <= 1'b0;
                        if (!r_write) data_out <= r_rx;
                    end else begin
                        spi_clk  <= 1'b0;
                        r_phase  <= 1'b0;
                        r_bit    <= r_bit + 5'd1;
                        spi_mosi <= r_frame[30];
                        r_frame  <= {r_frame[29:0], 1'b0};
                    end
                end
                DONE: begin
                    spi_cs  <= 1'b1;
                    spi_clk <= 1'b0;
                    if (!select) data_ready <= 1'b0;
                end
                default: begin
                    spi_cs     <= 1'b1;
                    spi_clk    <= 1'b0;
                    data_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
